// File: rtl/seg_scan_ctrl_if.sv
// Load handshake and display outputs of the multiplexed 3-digit seven-segment scanner.
interface seg_scan_ctrl_if;
  logic        LoadValid;
  logic        LoadReady;
  logic [11:0] LoadDigits;
  logic [2:0]  LoadDp;
  logic        LoadBlankLz;
  logic [7:0]  SevenSegment;
  logic [2:0]  Enable;
  logic        FrameDone;

  modport master (
    output LoadValid, LoadDigits, LoadDp, LoadBlankLz,
    input  LoadReady, SevenSegment, Enable, FrameDone
  );

  modport slave (
    input  LoadValid, LoadDigits, LoadDp, LoadBlankLz,
    output LoadReady, SevenSegment, Enable, FrameDone
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 3-digit hex display driver with blanking gaps and a tear-free
// one-entry shadow register that is committed only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned DIGIT_TICKS = 12000,
  parameter int unsigned BLANK_TICKS = 64
) (
  input logic           Clk,
  input logic           Reset,
  seg_scan_ctrl_if.slave bus
);

  localparam logic [15:0] DigLast   = 16'(DIGIT_TICKS - 1);
  localparam logic [15:0] BlankLast = 16'(BLANK_TICKS - 1);

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [15:0] cnt_q;
  logic [7:0]  seg_q;
  logic [2:0]  en_q;
  logic        fd_q;
  logic        ready_q;
  logic        pend_q;
  logic [11:0] sh_digits_q, act_digits_q;
  logic [2:0]  sh_dp_q, act_dp_q;
  logic        sh_blz_q, act_blz_q;

  logic        accept, boundary, pend_d, lz, dp_lit;
  logic [3:0]  nib;
  logic [7:0]  show_seg;
  logic [2:0]  show_en;

  // Active-low a..g for a hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    unique case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'ha: glyph = 7'b0001000;
      4'hb: glyph = 7'b1100000;
      4'hc: glyph = 7'b0110001;
      4'hd: glyph = 7'b1000010;
      4'he: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    nib     = act_digits_q[3:0];
    dp_lit  = act_dp_q[0];
    show_en = 3'b110;
    lz      = 1'b0;
    unique case (idx_q)
      2'd1: begin
        nib     = act_digits_q[7:4];
        dp_lit  = act_dp_q[1];
        show_en = 3'b101;
        lz      = act_blz_q && (act_digits_q[11:4] == 8'h00);
      end
      2'd2: begin
        nib     = act_digits_q[11:8];
        dp_lit  = act_dp_q[2];
        show_en = 3'b011;
        lz      = act_blz_q && (act_digits_q[11:8] == 4'h0);
      end
      default: ;
    endcase
    show_seg = {(lz ? 7'h7f : glyph(nib)), ~dp_lit};
  end

  assign accept   = bus.LoadValid && ready_q;
  assign boundary = (state_q == StShow) && (cnt_q == DigLast) && (idx_q == 2'd2);
  // Ready is deasserted while pending, so accept and pending never coexist.
  assign pend_d   = (pend_q && !boundary) || accept;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= StBlank;
      idx_q        <= 2'd0;
      cnt_q        <= 16'd0;
      seg_q        <= 8'hff;
      en_q         <= 3'b111;
      fd_q         <= 1'b0;
      ready_q      <= 1'b0;
      pend_q       <= 1'b0;
      sh_digits_q  <= 12'h000;
      sh_dp_q      <= 3'b000;
      sh_blz_q     <= 1'b0;
      act_digits_q <= 12'h000;
      act_dp_q     <= 3'b000;
      act_blz_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      unique case (state_q)
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_q <= StShow;
            cnt_q   <= 16'd0;
            seg_q   <= show_seg;
            en_q    <= show_en;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          if (cnt_q == DigLast) begin
            state_q <= StBlank;
            cnt_q   <= 16'd0;
            seg_q   <= 8'hff;
            en_q    <= 3'b111;
            idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            fd_q    <= (idx_q == 2'd2);
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      endcase

      if (boundary && pend_q) begin
        act_digits_q <= sh_digits_q;
        act_dp_q     <= sh_dp_q;
        act_blz_q    <= sh_blz_q;
      end
      if (accept) begin
        sh_digits_q <= bus.LoadDigits;
        sh_dp_q     <= bus.LoadDp;
        sh_blz_q    <= bus.LoadBlankLz;
      end
      pend_q  <= pend_d;
      ready_q <= !pend_d;
    end
  end

  assign bus.SevenSegment = seg_q;
  assign bus.Enable       = en_q;
  assign bus.FrameDone    = fd_q;
  assign bus.LoadReady    = ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: a frame-position reference model predicts every cycle's outputs.
module tb_seg_scan_ctrl;
  localparam int unsigned DT    = 4;
  localparam int unsigned BT    = 2;
  localparam int unsigned SLOT  = DT + BT;
  localparam int unsigned FRAME = 3 * SLOT;

  typedef struct packed {
    logic [7:0] seg;
    logic [2:0] en;
    logic       fd;
    logic       rdy;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  // Active-high abcdefg glyphs, index = hex value.
  logic [6:0] lit [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  int unsigned m_c;
  bit          m_ready, m_pend, m_acc;
  logic [11:0] m_sh_d, m_ac_d;
  logic [2:0]  m_sh_p, m_ac_p;
  logic        m_sh_b, m_ac_b;

  function automatic exp_t predict();
    exp_t        e;
    int unsigned pos, slot;
    logic [3:0]  nib;
    logic [11:0] dig;
    bit          lz;
    pos   = m_c % FRAME;
    slot  = pos / SLOT;
    e.fd  = (m_c != 0) && (pos == 0);
    e.rdy = m_ready;
    if ((pos % SLOT) < BT) begin
      e.seg = 8'hff;
      e.en  = 3'b111;
    end else begin
      dig   = m_ac_d >> (4 * slot);
      nib   = dig[3:0];
      lz    = m_ac_b && ((slot == 2 && m_ac_d[11:8] == 4'h0) ||
                         (slot == 1 && m_ac_d[11:4] == 8'h00));
      e.seg = {~(lz ? 7'h00 : lit[nib]), ~m_ac_p[slot]};
      e.en  = 3'b111 & ~(3'b001 << slot);
    end
    return e;
  endfunction

  task automatic tick(input logic v, input logic [11:0] d, input logic [2:0] p,
                      input logic b, input logic r);
    Reset           = r;
    bus.LoadValid   = v;
    bus.LoadDigits  = d;
    bus.LoadDp      = p;
    bus.LoadBlankLz = b;
    @(posedge Clk);
    if (r) begin
      m_c = 0; m_ready = 0; m_pend = 0; m_acc = 0;
      m_ac_d = '0; m_ac_p = '0; m_ac_b = 0;
    end else begin
      m_acc = v && m_ready;
      m_c++;
      if ((m_c % FRAME) == 0 && m_pend) begin
        m_ac_d = m_sh_d; m_ac_p = m_sh_p; m_ac_b = m_sh_b; m_pend = 0;
      end
      if (m_acc) begin
        m_sh_d = d; m_sh_p = p; m_sh_b = b; m_pend = 1;
      end
      m_ready = !m_pend;
    end
    q.push_back(predict());
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 12'h000, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [11:0] d, input logic [2:0] p, input logic b);
    int k = 0;
    do begin
      tick(1'b1, d, p, b, 1'b0);
      k++;
    end while (!m_acc && k < 200);
    if (!m_acc) begin
      errors++;
      $display("FAIL load_timeout got no accept required accept within 200 cycles");
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (done) break;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got output required queued expectation");
      end else begin
        e = q.pop_front();
        if (bus.SevenSegment !== e.seg) begin
          errors++;
          $display("FAIL seg t=%0t got %h required %h", $time, bus.SevenSegment, e.seg);
        end
        checks++;
        if (bus.Enable !== e.en) begin
          errors++;
          $display("FAIL enable t=%0t got %b required %b", $time, bus.Enable, e.en);
        end
        checks++;
        if (bus.FrameDone !== e.fd) begin
          errors++;
          $display("FAIL framedone t=%0t got %b required %b", $time, bus.FrameDone, e.fd);
        end
        checks++;
        if (bus.LoadReady !== e.rdy) begin
          errors++;
          $display("FAIL ready t=%0t got %b required %b", $time, bus.LoadReady, e.rdy);
        end
      end
    end
  end

  initial begin : driver
    int k;
    m_sh_d = '0; m_sh_p = '0; m_sh_b = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 12'hfff, 3'b111, 1'b1, 1'b1);
    idle(30);
    // Mid-frame load, then a second value held while the first is pending.
    while ((m_c % FRAME) != 7) idle(1);
    load(12'h123, 3'b010, 1'b0);
    load(12'h456, 3'b101, 1'b0);
    idle(60);
    load(12'h005, 3'b000, 1'b1);
    idle(60);
    // Reset during digit 1 with a load still pending.
    k = 0;
    while ((m_c % FRAME) != 1 && k < 100) begin idle(1); k++; end
    load(12'h9ab, 3'b111, 1'b0);
    k = 0;
    while ((m_c % FRAME) != SLOT + BT + 1 && k < 100) begin idle(1); k++; end
    tick(1'b0, 12'h000, 3'b000, 1'b0, 1'b1);
    idle(40);
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 2) == 0), 12'($urandom), 3'($urandom),
           1'($urandom), ($urandom_range(0, 299) == 0));
    end
    idle(40);
    done = 1'b1;
    @(posedge Clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_TICKS, default 12000, meaning clock cycles each digit is driven (1 ms at 12 MHz); legal range 2..65535.
REQ-002 SHALL have parameter BLANK_TICKS, default 64, meaning all-off cycles between digits (anti-ghosting); legal range 1..65535.
REQ-003 SHALL have port Clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port LoadValid  input  1  requester offers new display value.
REQ-006 SHALL have port LoadReady  output  1  controller can accept; transfer when LoadValid and LoadReady are both high at a rising edge.
REQ-007 SHALL have port LoadDigits  input  12  hex nibbles; [3:0] digit 0 (rightmost), [7:4] digit 1, [11:8] digit 2.
REQ-008 SHALL have port LoadDp  input  3  decimal point per digit, bit i = digit i, 1 = lit.
REQ-009 SHALL have port LoadBlankLz  input  1  leading-zero blanking enable.
REQ-010 SHALL have port SevenSegment  output  8  active-low segments: bit7=a, bit6=b, ... bit1=g, bit0=dp.
REQ-011 SHALL have port Enable  output  3  active-low digit enables, bit i = digit i.
REQ-012 SHALL have port FrameDone  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL implement FSM {BLANK, SHOW} with digit index 0..2 and a 16-bit tick counter.
REQ-014 BLANK SHALL last BLANK_TICKS cycles: Enable=3'b111, SevenSegment=8'hFF; then go to SHOW with same index.
REQ-015 SHOW SHALL last DIGIT_TICKS cycles: Enable bit[index]=0, others 1, SevenSegment = decode of active digit[index]; then go to BLANK with index+1, wrapping 2->0.
REQ-016 SevenSegment and Enable SHALL be registered and change on the same edge the FSM changes state (no extra latency).
REQ-017 Decode SHALL be full hex 0-F, segments per standard 7-seg glyphs (6, 9 with top/bottom bar; b, d lower-case; A, C, E, F upper-case).
REQ-018 Leading-zero blanking (active LoadBlankLz set): digit 2 segments a-g off if its nibble is 0; digit 1 off if digits 2 and 1 are both 0; digit 0 never blanked; dp still follows LoadDp; Enable unaffected.
REQ-019 SHALL hold an active register (digits, dp, blankLz) and a one-entry pending shadow register with a pending flag.
REQ-020 Accepted load SHALL write the shadow and set pending; LoadReady SHALL be registered and equal to NOT pending (0 in the cycle after acceptance).
REQ-021 Frame boundary = edge leaving SHOW of digit 2; at that edge: FrameDone=1 for the following cycle, and if pending then active<=shadow and pending cleared (tear-free update).
REQ-022 Load accepted on the boundary edge itself SHALL go to shadow and be applied at the next boundary, not the current one.
REQ-023 Display content SHALL never change mid-frame.

Reset
REQ-024 While Reset is high at an edge: state BLANK, index 0, counter 0, SevenSegment=8'hFF, Enable=3'b111, FrameDone=0, LoadReady=0, pending=0, active digits=12'h000, dp=3'b000, blankLz=0; loads ignored.
REQ-025 LoadReady SHALL be 1 in the first cycle after Reset deasserts; reset mid-operation SHALL discard pending and active content.

Verification (DIGIT_TICKS=4, BLANK_TICKS=2)
REQ-026 Reset then release -> 2 cycles FF/111, then Enable=110, SevenSegment=8'h03 ("0") for 4 cycles, then 2 blank cycles, then Enable=101.
REQ-027 Mid-frame load 12'h123, dp=3'b010 -> current frame unchanged, LoadReady=0 until boundary; next frame digit0 = 8'h0D ("3"), digit1 = 8'h24 ("2" with dp).
REQ-028 LoadValid held with second value while pending -> not accepted until cycle after boundary (LoadReady=1), displayed one frame later.
REQ-029 Load 12'h005, blankLz=1 -> digits 2 and 1 output 8'hFF with their Enable low, digit0 = 8'h49 ("5").
REQ-030 Reset pulsed during SHOW of digit 1 with pending load -> next cycle FF/111, LoadReady=0; after release shows "000", pending value never displayed.
REQ-031 Free run -> FrameDone pulses exactly every 18 cycles, one cycle wide.
